// File: rtl/core_types_pkg.sv
// Shared core-wide types and sizing defaults.
// The return-address stack takes its geometry and checkpoint record from here.
package core_types_pkg;

  localparam int RAS_ENTRIES      = 8;
  localparam int RAS_TARGET_WIDTH = 31;
  localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
  localparam int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1);

  // Snapshot taken alongside each predicted branch so a flush can rewind the stack.
  typedef struct packed {
    logic [RAS_INDEX_WIDTH-1:0] index;
    logic [RAS_COUNT_WIDTH-1:0] count;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_sat_counter.sv
// Saturating up-counter: increments on inc and holds at its all-ones maximum.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register; sticks at its maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ras_ckpt.sv
// Checkpointable circular return-address stack with zero-cycle top read.
// Define RAS_PERF_COUNTERS_EN to add saturating overflow/underflow event counters.
module ras_ckpt #(
  parameter  int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
  parameter  int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH,
  localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  localparam int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  input  logic                        restore_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
  input  logic [RAS_COUNT_WIDTH-1:0]  restore_count,
  output logic [RAS_TARGET_WIDTH-1:0] ret_target,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
  output logic                        ras_empty,
  output logic                        underflow
`ifdef RAS_PERF_COUNTERS_EN
  ,
  output logic [15:0]                 overflow_cnt,
  output logic [15:0]                 underflow_cnt
`else
`endif
);

  localparam logic [RAS_COUNT_WIDTH-1:0] FULL_COUNT = RAS_COUNT_WIDTH'(RAS_ENTRIES);

  logic [RAS_TARGET_WIDTH-1:0] stack_r [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  index_r;
  logic [RAS_COUNT_WIDTH-1:0]  count_r;

  logic [RAS_INDEX_WIDTH-1:0]  index_nxt_s;
  logic [RAS_COUNT_WIDTH-1:0]  count_nxt_s;
  logic                        wr_en_s;
  logic [RAS_INDEX_WIDTH-1:0]  wr_idx_s;
  logic                        ovf_evt_s;
  logic                        unf_evt_s;
  logic                        empty_s;

  assign empty_s = (count_r == {RAS_COUNT_WIDTH{1'b0}});

  // Next pointer/occupancy and write request; restore outranks push/pop.
  always_comb begin
    index_nxt_s = index_r;
    count_nxt_s = count_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = index_r;
    ovf_evt_s   = 1'b0;
    unf_evt_s   = 1'b0;
    if (restore_valid) begin
      index_nxt_s = restore_index;
      count_nxt_s = (restore_count > FULL_COUNT) ? FULL_COUNT : restore_count;
    end else if (push_valid && pop_valid) begin
      // A call that immediately returns just replaces the current top.
      wr_en_s = 1'b1;
    end else if (push_valid) begin
      wr_en_s     = 1'b1;
      wr_idx_s    = index_r + RAS_INDEX_WIDTH'(1);
      index_nxt_s = index_r + RAS_INDEX_WIDTH'(1);
      if (count_r == FULL_COUNT) begin
        ovf_evt_s = 1'b1;
      end else begin
        count_nxt_s = count_r + RAS_COUNT_WIDTH'(1);
      end
    end else if (pop_valid) begin
      if (empty_s) begin
        unf_evt_s = 1'b1;
      end else begin
        index_nxt_s = index_r - RAS_INDEX_WIDTH'(1);
        count_nxt_s = count_r - RAS_COUNT_WIDTH'(1);
      end
    end else begin
      index_nxt_s = index_r;
      count_nxt_s = count_r;
    end
  end

  // Top pointer and occupancy registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      index_r <= {RAS_INDEX_WIDTH{1'b0}};
      count_r <= {RAS_COUNT_WIDTH{1'b0}};
    end else begin
      index_r <= index_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; only the single addressed slot is written per cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        stack_r[i] <= {RAS_TARGET_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      stack_r[wr_idx_s] <= push_target;
    end
  end

  assign ret_target = stack_r[index_r];
  assign ras_index  = index_r;
  assign ras_count  = count_r;
  assign ras_empty  = empty_s;
  // Flag any pop seen against an empty stack, but never while reset or recovery owns the cycle.
  assign underflow  = pop_valid & empty_s & ~restore_valid & ~RST;

`ifdef RAS_PERF_COUNTERS_EN
  sat_counter #(.WIDTH(16)) u_ovf_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (ovf_evt_s),
    .count (overflow_cnt)
  );

  sat_counter #(.WIDTH(16)) u_unf_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (unf_evt_s),
    .count (underflow_cnt)
  );
`else
  logic perf_unused_s;
  assign perf_unused_s = ovf_evt_s | unf_evt_s;
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: directed scenarios plus randomized traffic against a stack model.
module tb_ras_ckpt;

  localparam int N  = 8;
  localparam int TW = 31;
  localparam int IW = 3;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          push_valid = 1'b0;
  logic [TW-1:0] push_target = '0;
  logic          pop_valid = 1'b0;
  logic          restore_valid = 1'b0;
  logic [IW-1:0] restore_index = '0;
  logic [CW-1:0] restore_count = '0;
  logic [TW-1:0] ret_target;
  logic [IW-1:0] ras_index;
  logic [CW-1:0] ras_count;
  logic          ras_empty;
  logic          underflow;
`ifdef RAS_PERF_COUNTERS_EN
  logic [15:0]   overflow_cnt;
  logic [15:0]   underflow_cnt;
`endif

  ras_ckpt dut (
    .CLK           (CLK),
    .RST           (RST),
    .push_valid    (push_valid),
    .push_target   (push_target),
    .pop_valid     (pop_valid),
    .restore_valid (restore_valid),
    .restore_index (restore_index),
    .restore_count (restore_count),
    .ret_target    (ret_target),
    .ras_index     (ras_index),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty),
    .underflow     (underflow)
`ifdef RAS_PERF_COUNTERS_EN
    ,
    .overflow_cnt  (overflow_cnt),
    .underflow_cnt (underflow_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit running = 1'b1;

  // Reference model: plain array with modular top pointer and an occupancy number.
  logic [TW-1:0] m_stack [N];
  int m_idx = 0;
  int m_cnt = 0;
  int m_ovf = 0;
  int m_unf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_stack[i] = '0;
    m_idx = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step();
    if (RST) begin
      model_reset();
    end else if (restore_valid) begin
      m_idx = int'(restore_index);
      m_cnt = (int'(restore_count) > N) ? N : int'(restore_count);
    end else if (push_valid && pop_valid) begin
      m_stack[m_idx] = push_target;
    end else if (push_valid) begin
      m_idx = (m_idx + 1) % N;
      m_stack[m_idx] = push_target;
      if (m_cnt == N) begin
        if (m_ovf < 65535) m_ovf++;
      end else begin
        m_cnt++;
      end
    end else if (pop_valid) begin
      if (m_cnt == 0) begin
        if (m_unf < 65535) m_unf++;
      end else begin
        m_idx = (m_idx + N - 1) % N;
        m_cnt--;
      end
    end
  endtask

  task automatic drv(input logic pu, input logic [TW-1:0] t, input logic po,
                     input logic rv, input logic [IW-1:0] ri, input logic [CW-1:0] rc);
    push_valid    = pu;
    push_target   = t;
    pop_valid     = po;
    restore_valid = rv;
    restore_index = ri;
    restore_count = rc;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic pu, input logic [TW-1:0] t, input logic po,
                     input logic rv, input logic [IW-1:0] ri, input logic [CW-1:0] rc);
    drv(pu, t, po, rv, ri, rc);
    tick();
  endtask

  task automatic do_push(input logic [TW-1:0] t);
    cyc(1'b1, t, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_pop();
    cyc(1'b0, '0, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);
    RST = 1'b0;
  endtask

  // Every falling edge: all outputs against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (running) begin
        chk("ret_target", 64'(ret_target), 64'(m_stack[m_idx]));
        chk("ras_index", 64'(ras_index), 64'(m_idx));
        chk("ras_count", 64'(ras_count), 64'(m_cnt));
        chk("ras_empty", 64'(ras_empty), 64'(m_cnt == 0));
        chk("underflow", 64'(underflow),
            64'(pop_valid && (m_cnt == 0) && !restore_valid && !RST));
`ifdef RAS_PERF_COUNTERS_EN
        chk("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
        chk("underflow_cnt", 64'(underflow_cnt), 64'(m_unf));
`endif
      end
    end
  end

  initial begin
    logic [IW-1:0] ci;
    logic [CW-1:0] cc;
    int r;

    model_reset();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);
    RST = 1'b0;
    chk("rst_count", 64'(ras_count), 64'd0);
    chk("rst_index", 64'(ras_index), 64'd0);
    chk("rst_ret", 64'(ret_target), 64'd0);
    chk("rst_empty", 64'(ras_empty), 64'd1);

    // Basic push/pop
    do_push(31'h100);
    do_push(31'h200);
    do_push(31'h300);
    chk("basic_count", 64'(ras_count), 64'd3);
    chk("basic_index", 64'(ras_index), 64'd3);
    chk("basic_ret", 64'(ret_target), 64'h300);
    do_pop();
    chk("basic_pop_ret", 64'(ret_target), 64'h200);
    chk("basic_pop_count", 64'(ras_count), 64'd2);

    // Wrap past depth
    do_reset();
    for (int v = 1; v <= 10; v++) do_push(TW'(v));
    chk("wrap_count", 64'(ras_count), 64'd8);
    chk("wrap_index", 64'(ras_index), 64'd2);
`ifdef RAS_PERF_COUNTERS_EN
    chk("wrap_ovf_cnt", 64'(overflow_cnt), 64'd2);
`endif
    for (int k = 0; k < 8; k++) begin
      chk("wrap_pop_ret", 64'(ret_target), 64'(10 - k));
      do_pop();
    end
    chk("wrap_empty", 64'(ras_empty), 64'd1);

    // Pop on empty
    do_reset();
    drv(1'b0, '0, 1'b1, 1'b0, '0, '0);
    #2;
    chk("unf_flag", 64'(underflow), 64'd1);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("unf_index", 64'(ras_index), 64'd0);
    chk("unf_count", 64'(ras_count), 64'd0);
`ifdef RAS_PERF_COUNTERS_EN
    chk("unf_cnt", 64'(underflow_cnt), 64'd1);
`endif

    // Push and pop together
    do_reset();
    do_push(31'h100);
    do_push(31'h200);
    drv(1'b1, 31'h500, 1'b1, 1'b0, '0, '0);
    #2;
    chk("pp_old_ret", 64'(ret_target), 64'h200);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("pp_index", 64'(ras_index), 64'd2);
    chk("pp_count", 64'(ras_count), 64'd2);
    chk("pp_ret", 64'(ret_target), 64'h500);

    // Checkpoint restore beats a concurrent push
    do_reset();
    do_push(31'hA1);
    do_push(31'hA2);
    ci = ras_index;
    cc = ras_count;
    chk("ckpt_index", 64'(ci), 64'd2);
    do_push(31'hB1);
    do_push(31'hB2);
    do_push(31'hB3);
    cyc(1'b1, 31'hDEAD, 1'b0, 1'b1, ci, cc);
    chk("rest_index", 64'(ras_index), 64'd2);
    chk("rest_count", 64'(ras_count), 64'd2);
    chk("rest_ret", 64'(ret_target), 64'hA2);
    cyc(1'b0, '0, 1'b0, 1'b1, 3'd6, 4'd15);
    chk("rest_nowrite", 64'(ret_target), 64'd0);
    chk("rest_clamp", 64'(ras_count), 64'd8);

    // Asynchronous reset mid-sequence
    do_reset();
    for (int v = 1; v <= 5; v++) do_push(TW'(v * 16));
    chk("pre_rst_count", 64'(ras_count), 64'd5);
    drv(1'b1, 31'h77, 1'b1, 1'b0, '0, '0);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    chk("arst_count", 64'(ras_count), 64'd0);
    chk("arst_index", 64'(ras_index), 64'd0);
    chk("arst_ret", 64'(ret_target), 64'd0);
    chk("arst_empty", 64'(ras_empty), 64'd1);
    chk("arst_unf", 64'(underflow), 64'd0);
    tick();
    RST = 1'b0;
    drv(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      RST = (r == 0);
      if (RST) model_reset();
      cyc(1'($urandom), TW'($urandom), 1'($urandom), (r < 8),
          IW'($urandom), CW'($urandom));
    end
    RST = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);

    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
